// File: rtl/lab3_cache_mem_responder_pkg.sv
// Shared memory-message types, type constants, FSM encodings and byte-lane helpers
// for the lab3 cache memory responder.
package lab3_cache_mem_responder_pkg;

    localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
    localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        WAIT = ST_WAIT,
        RESP = ST_RESP
    } state_e;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_req_4B_t;

    typedef struct packed {
        logic [2:0]  type_;
        logic [7:0]  opaque;
        logic [1:0]  test;
        logic [1:0]  len;
        logic [31:0] data;
    } mem_resp_4B_t;

    // len 0 means a full word; lanes shifted past byte 3 fall off the 4-bit mask
    function automatic logic [3:0] lane_mask(input logic [1:0] off, input logic [1:0] len);
        logic [3:0] base;
        base = (len == 2'd0) ? 4'hF : ((4'd1 << len) - 4'd1);
        return base << off;
    endfunction

    function automatic logic [31:0] read_align(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] len);
        logic [31:0] mask;
        mask = (len == 2'd0) ? 32'hFFFF_FFFF : ((32'd1 << {len, 3'b000}) - 32'd1);
        return (word >> {off, 3'b000}) & mask;
    endfunction

endpackage

// File: rtl/lab3_cache_mem_responder_if.sv
// Request/response val/rdy bundle between a cache memory port (master) and the responder (slave).
interface lab3_cache_mem_responder_if;
    import lab3_cache_mem_responder_pkg::*;

    logic         memreq_val;
    logic         memreq_rdy;
    mem_req_4B_t  memreq_msg;
    logic         memresp_val;
    logic         memresp_rdy;
    mem_resp_4B_t memresp_msg;

    modport master (
        output memreq_val, memreq_msg, memresp_rdy,
        input  memreq_rdy, memresp_val, memresp_msg
    );

    modport slave (
        input  memreq_val, memreq_msg, memresp_rdy,
        output memreq_rdy, memresp_val, memresp_msg
    );
endinterface

// File: rtl/lab3_cache_mem_responder_reqqueue2.sv
// Two-entry request FIFO; a full queue still accepts when the head leaves in the same cycle.
module lab3_cache_ReqQueue2
    import lab3_cache_mem_responder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enq_val,
    output logic        enq_rdy,
    input  mem_req_4B_t enq_msg,
    output logic        deq_val,
    input  logic        deq_rdy,
    output mem_req_4B_t deq_msg,
    output logic        full,
    output logic        empty
);
    mem_req_4B_t entry_q [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        enq_fire, deq_fire;

    always_comb begin
        full     = (count_q == 2'd2);
        empty    = (count_q == 2'd0);
        deq_val  = !empty;
        deq_msg  = entry_q[rd_ptr_q];
        enq_rdy  = !full || deq_rdy;
        enq_fire = enq_val && enq_rdy;
        deq_fire = deq_val && deq_rdy;
        wr_ptr_d = wr_ptr_q ^ enq_fire;
        rd_ptr_d = rd_ptr_q ^ deq_fire;
        count_d  = count_q + {1'b0, enq_fire} - {1'b0, deq_fire};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) entry_q[wr_ptr_q] <= enq_msg;
    end
endmodule

// File: rtl/lab3_cache_mem_responder.sv
// Test memory behind a cache: queues requests, waits p_latency cycles, then answers in order.
// Define LAB3_CACHE_MEM_RAND_DELAY_EN to add 0..3 LFSR-driven extra wait cycles per request.
module lab3_cache_mem_responder
    import lab3_cache_mem_responder_pkg::*;
#(
    parameter int p_num_words = 256,
    parameter int p_latency   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    input  mem_req_4B_t  memreq_msg,
    output logic         memresp_val,
    input  logic         memresp_rdy,
    output mem_resp_4B_t memresp_msg
);
    localparam int         AW  = $clog2(p_num_words);
    localparam logic [4:0] LAT = 5'(p_latency);

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d, load_cnt;
    mem_req_4B_t act_q, act_d, acc_req, fifo_deq_msg;
    logic        fifo_deq_val, fifo_deq_rdy, fifo_full, fifo_enq_val;
    logic        unused_fifo_enq_rdy, unused_fifo_empty, unused_acc_bits;
    logic        deq_fire, acc_fire, mem_we, mem_re;
    logic [AW-1:0] acc_idx;
    logic [3:0]  acc_be;
    logic [31:0] acc_wdata, rd_word;

    assign memreq_rdy   = !reset && !fifo_full;
    assign fifo_enq_val = memreq_val && memreq_rdy;

    lab3_cache_ReqQueue2 u_queue (
        .clk     (clk),
        .reset   (reset),
        .enq_val (fifo_enq_val),
        .enq_rdy (unused_fifo_enq_rdy),
        .enq_msg (memreq_msg),
        .deq_val (fifo_deq_val),
        .deq_rdy (fifo_deq_rdy),
        .deq_msg (fifo_deq_msg),
        .full    (fifo_full),
        .empty   (unused_fifo_empty)
    );

`ifdef LAB3_CACHE_MEM_RAND_DELAY_EN
    logic [7:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (deq_fire) lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end

    assign load_cnt = LAT + {3'b000, lfsr_q[1:0]};
`else
    assign load_cnt = LAT;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        act_d        = act_q;
        acc_req      = act_q;
        acc_fire     = 1'b0;
        fifo_deq_rdy = (state_q == IDLE) || ((state_q == RESP) && memresp_rdy);
        deq_fire     = fifo_deq_rdy && fifo_deq_val;
        case (state_q)
            IDLE: ;
            WAIT: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d  = RESP;
                    acc_fire = 1'b1;
                end
            end
            RESP: if (memresp_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A dequeue overrides the IDLE/RESP outcome; zero latency goes straight to the access
        if (deq_fire) begin
            act_d = fifo_deq_msg;
            cnt_d = load_cnt;
            if (load_cnt == 5'd0) begin
                state_d  = RESP;
                acc_fire = 1'b1;
                acc_req  = fifo_deq_msg;
            end else begin
                state_d = WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            act_q   <= act_d;
        end
    end

    assign acc_idx   = acc_req.addr[AW+1:2];
    assign acc_be    = lane_mask(acc_req.addr[1:0], acc_req.len);
    assign acc_wdata = acc_req.data << {acc_req.addr[1:0], 3'b000};
    assign mem_we    = acc_fire && !reset && (acc_req.type_ == MEM_TYPE_WRITE);
    assign mem_re    = acc_fire && !reset && (acc_req.type_ == MEM_TYPE_READ);
    assign unused_acc_bits = ^{acc_req.addr[31:AW+2], acc_req.opaque};

    // One RAM per byte lane so partial writes need no read-modify-write; contents survive reset
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] mem_lane [p_num_words];
        logic [7:0] rd_byte_q;

        always_ff @(posedge clk) begin
            if (mem_we && acc_be[gi]) mem_lane[acc_idx] <= acc_wdata[8*gi +: 8];
            if (mem_re)               rd_byte_q         <= mem_lane[acc_idx];
        end

        assign rd_word[8*gi +: 8] = rd_byte_q;
    end

    always_comb begin
        memresp_val        = (state_q == RESP) && !reset;
        memresp_msg.type_  = act_q.type_;
        memresp_msg.opaque = act_q.opaque;
        memresp_msg.test   = 2'd0;
        memresp_msg.len    = act_q.len;
        memresp_msg.data   = (act_q.type_ == MEM_TYPE_READ)
                             ? read_align(rd_word, act_q.addr[1:0], act_q.len) : 32'd0;
    end
endmodule

// File: tb/tb_lab3_cache_mem_responder.sv
// Scoreboard bench for lab3_cache_mem_responder: directed requests push expected responses,
// a monitor pops and compares each handshaken response and checks hold stability.
module tb_lab3_cache_mem_responder;
    import lab3_cache_mem_responder_pkg::*;

    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0, checks = 0, errors = 0, acc_count = 0, acc_cyc = 0;
    mem_resp_4B_t exp_q[$];

    lab3_cache_mem_responder_if bus();

    lab3_cache_mem_responder #(.p_num_words(256), .p_latency(LAT)) dut (
        .clk         (clk),
        .reset       (reset),
        .memreq_val  (bus.memreq_val),
        .memreq_rdy  (bus.memreq_rdy),
        .memreq_msg  (bus.memreq_msg),
        .memresp_val (bus.memresp_val),
        .memresp_rdy (bus.memresp_rdy),
        .memresp_msg (bus.memresp_msg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic mem_resp_4B_t mk_resp(logic [2:0] t, logic [7:0] op, logic [1:0] l,
                                             logic [31:0] d);
        mem_resp_4B_t r;
        r.type_  = t;
        r.opaque = op;
        r.test   = 2'd0;
        r.len    = l;
        r.data   = d;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [2:0] t, input logic [7:0] op, input logic [31:0] a,
                        input logic [1:0] l, input logic [31:0] d, input logic [31:0] exp_d,
                        input bit want);
        mem_req_4B_t m;
        int n = 0;
        m.type_ = t; m.opaque = op; m.addr = a; m.len = l; m.data = d;
        bus.memreq_msg = m;
        bus.memreq_val = 1'b1;
        while (!bus.memreq_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.memreq_rdy) begin
            checks++;
            errors++;
            $display("FAIL accept op=%h: memreq_rdy stayed 0, required 1", op);
            bus.memreq_val = 1'b0;
        end else begin
            if (want) exp_q.push_back(mk_resp(t, op, l, exp_d));
            acc_cyc = cyc;
            acc_count++;
            $display("req  type=%0d op=%h addr=%h len=%0d data=%h", t, op, a, l, d);
            @(negedge clk);
            bus.memreq_val = 1'b0;
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bus.memresp_val) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", exp_q.size(), 0);
    endtask

    initial begin : monitor
        mem_resp_4B_t e, hold_msg;
        logic hold_pending;
        hold_pending = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (reset) begin
                hold_pending = 1'b0;
            end else if (bus.memresp_val) begin
                if (hold_pending) begin
                    checks++;
                    if (bus.memresp_msg !== hold_msg) begin
                        errors++;
                        $display("FAIL hold: msg %h changed while stalled, required %h",
                                 bus.memresp_msg, hold_msg);
                    end
                end
                if (bus.memresp_rdy) begin
                    hold_pending = 1'b0;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL resp: unexpected response %h, required none", bus.memresp_msg);
                    end else begin
                        e = exp_q.pop_front();
                        $display("resp type=%0d op=%h len=%0d test=%0d data=%h",
                                 bus.memresp_msg.type_, bus.memresp_msg.opaque,
                                 bus.memresp_msg.len, bus.memresp_msg.test, bus.memresp_msg.data);
                        if (bus.memresp_msg !== e) begin
                            errors++;
                            $display("FAIL resp op=%h: got type=%0d op=%h len=%0d test=%0d data=%h, required type=%0d op=%h len=%0d test=0 data=%h",
                                     e.opaque, bus.memresp_msg.type_, bus.memresp_msg.opaque,
                                     bus.memresp_msg.len, bus.memresp_msg.test, bus.memresp_msg.data,
                                     e.type_, e.opaque, e.len, e.data);
                        end
                    end
                end else begin
                    hold_pending = 1'b1;
                    hold_msg     = bus.memresp_msg;
                end
            end else begin
                hold_pending = 1'b0;
            end
        end
    end

    initial begin : main
        int got_lat;
        bus.memreq_val  = 1'b0;
        bus.memreq_msg  = '0;
        bus.memresp_rdy = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_resp_val", bus.memresp_val, 0);
        check("rst_req_rdy", bus.memreq_rdy, 0);
        reset = 1'b0;
        #1;
        check("post_rst_req_rdy", bus.memreq_rdy, 1);
        check("post_rst_resp_val", bus.memresp_val, 0);
        @(negedge clk);

        // Write then read the same word, measuring read latency from an idle start
        send(MEM_TYPE_WRITE, 8'h01, 32'h100, 2'd0, 32'hDEADBEEF, 32'h0, 1'b1);
        drain();
        send(MEM_TYPE_READ, 8'h02, 32'h100, 2'd0, 32'h0, 32'hDEADBEEF, 1'b1);
        got_lat = -1;
        for (int i = 0; i < 40 && got_lat < 0; i++) begin
            if (bus.memresp_val) got_lat = cyc - acc_cyc;
            else @(negedge clk);
        end
`ifdef LAB3_CACHE_MEM_RAND_DELAY_EN
        check("latency_in_range", (got_lat >= 2 + LAT && got_lat <= 5 + LAT) ? 1 : 0, 1);
`else
        check("latency", got_lat, 2 + LAT);
`endif
        drain();

        // Byte-lane writes and aligned/shifted reads
        send(MEM_TYPE_WRITE, 8'h03, 32'h200, 2'd0, 32'h11223344, 32'h0, 1'b1);
        send(MEM_TYPE_WRITE, 8'h04, 32'h202, 2'd1, 32'h000000AA, 32'h0, 1'b1);
        send(MEM_TYPE_READ,  8'h05, 32'h200, 2'd0, 32'h0, 32'h11AA3344, 1'b1);
        send(MEM_TYPE_READ,  8'h06, 32'h201, 2'd2, 32'h0, 32'h0000AA33, 1'b1);
        send(MEM_TYPE_READ,  8'h07, 32'h203, 2'd1, 32'h0, 32'h00000011, 1'b1);
        send(MEM_TYPE_READ,  8'h08, 32'h202, 2'd0, 32'h0, 32'h000011AA, 1'b1);
        send(MEM_TYPE_WRITE, 8'h09, 32'h208, 2'd0, 32'h00000000, 32'h0, 1'b1);
        send(MEM_TYPE_WRITE, 8'h0A, 32'h20A, 2'd3, 32'h00CCBBAA, 32'h0, 1'b1);
        send(MEM_TYPE_READ,  8'h0B, 32'h208, 2'd0, 32'h0, 32'hBBAA0000, 1'b1);

        // Address wrap and unknown request type
        send(MEM_TYPE_WRITE, 8'h0C, 32'h400, 2'd0, 32'h00000005, 32'h0, 1'b1);
        send(MEM_TYPE_READ,  8'h0D, 32'h000, 2'd0, 32'h0, 32'h00000005, 1'b1);
        send(3'd2,           8'h0E, 32'h000, 2'd0, 32'h00000099, 32'h0, 1'b1);
        send(MEM_TYPE_READ,  8'h0F, 32'h000, 2'd0, 32'h0, 32'h00000005, 1'b1);

        send(MEM_TYPE_WRITE, 8'h10, 32'h300, 2'd0, 32'hA0A0A0A0, 32'h0, 1'b1);
        send(MEM_TYPE_WRITE, 8'h11, 32'h304, 2'd0, 32'hB1B1B1B1, 32'h0, 1'b1);
        send(MEM_TYPE_WRITE, 8'h12, 32'h308, 2'd0, 32'hC2C2C2C2, 32'h0, 1'b1);
        drain();

        // Back-pressure: response side stalled for 20 cycles
        bus.memresp_rdy = 1'b0;
        acc_count = 0;
        fork
            begin
                send(MEM_TYPE_READ, 8'h30, 32'h100, 2'd0, 32'h0, 32'hDEADBEEF, 1'b1);
                send(MEM_TYPE_READ, 8'h31, 32'h200, 2'd0, 32'h0, 32'h11AA3344, 1'b1);
                send(MEM_TYPE_READ, 8'h32, 32'h208, 2'd0, 32'h0, 32'hBBAA0000, 1'b1);
                send(MEM_TYPE_READ, 8'h33, 32'h000, 2'd0, 32'h0, 32'h00000005, 1'b1);
            end
            begin
                repeat (20) @(negedge clk);
                check("accepts_while_stalled", acc_count, 3);
                check("req_rdy_while_stalled", bus.memreq_rdy, 0);
                bus.memresp_rdy = 1'b1;
            end
        join
        drain();

        // Reset while the first write waits and two more are queued: none may commit
        send(MEM_TYPE_WRITE, 8'h20, 32'h300, 2'd0, 32'h11111111, 32'h0, 1'b0);
        send(MEM_TYPE_WRITE, 8'h21, 32'h304, 2'd0, 32'h22222222, 32'h0, 1'b0);
        send(MEM_TYPE_WRITE, 8'h22, 32'h308, 2'd0, 32'h33333333, 32'h0, 1'b0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_rst_resp_val", bus.memresp_val, 0);
        check("mid_rst_req_rdy", bus.memreq_rdy, 0);
        reset = 1'b0;
        #1;
        check("mid_post_rst_req_rdy", bus.memreq_rdy, 1);
        @(negedge clk);
        check("mid_post_rst_resp_val", bus.memresp_val, 0);
        send(MEM_TYPE_READ, 8'h23, 32'h300, 2'd0, 32'h0, 32'hA0A0A0A0, 1'b1);
        send(MEM_TYPE_READ, 8'h24, 32'h304, 2'd0, 32'h0, 32'hB1B1B1B1, 1'b1);
        send(MEM_TYPE_READ, 8'h25, 32'h308, 2'd0, 32'h0, 32'hC2C2C2C2, 1'b1);
        drain();

        // Read immediately behind a write to the same word
        send(MEM_TYPE_WRITE, 8'h40, 32'h010, 2'd0, 32'h12345678, 32'h0, 1'b1);
        send(MEM_TYPE_READ,  8'h41, 32'h010, 2'd0, 32'h0, 32'h12345678, 1'b1);
        send(MEM_TYPE_READ,  8'h42, 32'h011, 2'd3, 32'h0, 32'h00123456, 1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lab3_cache_mem_responder.md
LAB3_CACHE_MEM_RESPONDER -- requirements
Module: lab3_cache_mem_responder

Interface
REQ-001 SHALL have parameter p_num_words, default 256: memory depth in 32-bit words (power of 2, 16..4096).
REQ-002 SHALL have parameter p_latency, default 2: extra cycles between request dequeue and response valid (0..15).
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on posedge clk.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports memreq_val (input, 1), memreq_rdy (output, 1) and memreq_msg (input, mem_req_4B_t): request stream from the cache's memory side.
REQ-006 SHALL have ports memresp_val (output, 1), memresp_rdy (input, 1) and memresp_msg (output, mem_resp_4B_t): response stream to the cache.

Function
REQ-007 SHALL transfer a request or response only in a cycle where val && rdy; memresp_msg SHALL be held stable while memresp_val && !memresp_rdy.
REQ-008 SHALL buffer accepted requests in a 2-entry FIFO; memreq_rdy = FIFO not full; enqueue and dequeue in the same cycle on a full FIFO SHALL be allowed.
REQ-009 SHALL run an FSM with states IDLE, WAIT, RESP; reset state IDLE.
REQ-010 IDLE: if FIFO non-empty, dequeue the head into the active register, load the latency counter with p_latency, and go to WAIT (p_latency>0) or RESP (p_latency=0).
REQ-011 WAIT: decrement the counter each cycle; on reaching 0 go to RESP.
REQ-012 SHALL perform the memory access (read capture or write commit) on the transition into RESP, so an accept in cycle T into an empty FIFO with FSM idle gives memresp_val first high in cycle T+2+p_latency.
REQ-013 RESP: memresp_val=1; on memresp_rdy, go to IDLE; if the FIFO is non-empty in that cycle, dequeue and load directly (IDLE skipped).
REQ-014 Word index SHALL be addr[$clog2(p_num_words)+1:2]; upper address bits SHALL be ignored (wrap-around).
REQ-015 len=0 SHALL mean 4 bytes; len=1..3 SHALL mean that many bytes starting at byte lane addr[1:0]; lanes past byte 3 SHALL be dropped.
REQ-016 Write (type_=1) SHALL update only the selected byte lanes; response data SHALL be 0.
REQ-017 Read (type_=0) SHALL return the word shifted right by 8*addr[1:0] with bytes above len zeroed.
REQ-018 Any other type_ SHALL leave memory unchanged and respond with data 0.
REQ-019 Response type_, opaque and len SHALL echo the request; test SHALL be 0.
REQ-020 Requests SHALL be serviced strictly in order, one outstanding access; a read after a write to the same word SHALL return the written data.

Reset
REQ-021 Reset SHALL empty the FIFO, set FSM to IDLE, clear the counter, and force memresp_val=0 and memreq_rdy=0 during reset, with memreq_rdy=1 in the first cycle after reset.
REQ-022 Reset mid-operation SHALL drop the active and queued requests without writing memory; memory contents SHALL NOT be reset.

Configuration
REQ-023 With LAB3_CACHE_MEM_RAND_DELAY_EN defined, SHALL add 0..3 extra WAIT cycles per request taken from bits [1:0] of an 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset, advanced once per dequeue).
REQ-024 Without LAB3_CACHE_MEM_RAND_DELAY_EN, latency SHALL be exactly p_latency; the LFSR SHALL not exist.

Structure
REQ-025 mem_req_4B_t, mem_resp_4B_t and the type constants SHALL come from the shared vc memory-message package; FSM state encodings SHALL be localparams.
REQ-026 The 2-entry FIFO SHALL be a sub-module lab3_cache_ReqQueue2 (val/rdy enq and deq, full/empty outputs).

Verification
REQ-027 Write addr 0x100 data 0xDEADBEEF len 0, then read 0x100 -> read response data 0xDEADBEEF, opaque echoed, test 0.
REQ-028 p_latency=2, single read accepted at cycle 10, memresp_rdy=1 -> memresp_val first high at cycle 14.
REQ-029 Write 0x11223344 to 0x200, then write len 1 data 0xAA at 0x202, then read 0x200 len 0 -> 0x11AA3344; read 0x201 len 2 -> 0x0000AA33.
REQ-030 Four back-to-back requests with memresp_rdy=0 for 20 cycles -> memreq_rdy drops after 3 accepts, memresp_msg stable, then all 4 responses return in order.
REQ-031 p_num_words=256, write 0x5 to 0x400, read 0x0 -> 0x5 (wrap).
REQ-032 Assert reset while in WAIT with 2 queued writes -> memresp_val=0 after reset, and reads of those addresses return the old contents.
